// File: rtl/execute_stage.sv
// Execute stage of the five-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and the execute/memory pipeline register.
module execute_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int WRITE_WIDTH   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     regwritee,
    input  logic [1:0]               resultsrce,
    input  logic                     memwritee,
    input  logic                     jumpe,
    input  logic                     jalre,
    input  logic                     branche,
    input  logic [2:0]               alucontrole,
    input  logic                     alusrce,
    input  logic [DATA_WIDTH-1:0]    rd1e,
    input  logic [DATA_WIDTH-1:0]    rd2e,
    input  logic [DATA_WIDTH-1:0]    immexte,
    input  logic [ADDRESS_WIDTH-1:0] pce,
    input  logic [ADDRESS_WIDTH-1:0] pcplus4e,
    input  logic [WRITE_WIDTH-1:0]   rde,
    input  logic [1:0]               forwardae,
    input  logic [1:0]               forwardbe,
    input  logic [DATA_WIDTH-1:0]    resultw,
    output logic                     pcsrce,
    output logic [ADDRESS_WIDTH-1:0] pctargete,
    output logic                     regwritem,
    output logic                     memwritem,
    output logic [1:0]               resultsrcm,
    output logic [DATA_WIDTH-1:0]    aluresultm,
    output logic [DATA_WIDTH-1:0]    writedatam,
    output logic [WRITE_WIDTH-1:0]   rdm,
    output logic [ADDRESS_WIDTH-1:0] pcplus4m
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    logic [DATA_WIDTH-1:0] srca, writedatae, srcb, aluresult, jalr_sum;
    logic                  zero;

    // Forwarding muxes; code 11 is unused by the hazard unit and falls back to the register file.
    always_comb begin
        srca = rd1e;
        case (forwardae)
            2'b01:   srca = resultw;
            2'b10:   srca = aluresultm;
            default: srca = rd1e;
        endcase
        writedatae = rd2e;
        case (forwardbe)
            2'b01:   writedatae = resultw;
            2'b10:   writedatae = aluresultm;
            default: writedatae = rd2e;
        endcase
        srcb = alusrce ? immexte : writedatae;
    end

    // ALU: all ops wrap modulo 2^DATA_WIDTH; shifts use only the low bits of SrcB.
    always_comb begin
        aluresult = '0;
        case (alu_op_t'(alucontrole))
            ALU_ADD: aluresult = srca + srcb;
            ALU_SUB: aluresult = srca - srcb;
            ALU_AND: aluresult = srca & srcb;
            ALU_OR:  aluresult = srca | srcb;
            ALU_XOR: aluresult = srca ^ srcb;
            ALU_SLT: aluresult = {{(DATA_WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            ALU_SLL: aluresult = srca << srcb[SHW-1:0];
            ALU_SRL: aluresult = srca >> srcb[SHW-1:0];
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);

    // Branch/jump resolution feeds fetch directly; JALR target wins and has bit 0 cleared.
    always_comb begin
        jalr_sum  = srca + immexte;
        pcsrce    = jumpe | jalre | (branche & zero);
        pctargete = pce + ADDRESS_WIDTH'(immexte);
        if (jalre)
            pctargete = ADDRESS_WIDTH'({jalr_sum[DATA_WIDTH-1:1], 1'b0});
    end

    // E/M pipeline register; reset squashes the in-flight instruction entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwritem  <= 1'b0;
            memwritem  <= 1'b0;
            resultsrcm <= '0;
            aluresultm <= '0;
            writedatam <= '0;
            rdm        <= '0;
            pcplus4m   <= '0;
        end else begin
            regwritem  <= regwritee;
            memwritem  <= memwritee;
            resultsrcm <= resultsrce;
            aluresultm <= aluresult;
            writedatam <= writedatae;
            rdm        <= rde;
            pcplus4m   <= pcplus4e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: table of single-cycle vectors plus
// hand-written reset sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwritee, memwritee, jumpe, jalre, branche, alusrce;
    logic [1:0]  resultsrce, forwardae, forwardbe;
    logic [2:0]  alucontrole;
    logic [31:0] rd1e, rd2e, immexte, pce, pcplus4e, resultw;
    logic [4:0]  rde;
    logic        pcsrce, regwritem, memwritem;
    logic [31:0] pctargete, aluresultm, writedatam, pcplus4m;
    logic [1:0]  resultsrcm;
    logic [4:0]  rdm;

    int errors = 0;
    int checks = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .regwritee(regwritee), .resultsrce(resultsrce),
        .memwritee(memwritee), .jumpe(jumpe), .jalre(jalre), .branche(branche),
        .alucontrole(alucontrole), .alusrce(alusrce), .rd1e(rd1e), .rd2e(rd2e),
        .immexte(immexte), .pce(pce), .pcplus4e(pcplus4e), .rde(rde),
        .forwardae(forwardae), .forwardbe(forwardbe), .resultw(resultw),
        .pcsrce(pcsrce), .pctargete(pctargete), .regwritem(regwritem),
        .memwritem(memwritem), .resultsrcm(resultsrcm), .aluresultm(aluresultm),
        .writedatam(writedatam), .rdm(rdm), .pcplus4m(pcplus4m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [2:0]  op;
        logic        asrc;
        logic [31:0] rd1, rd2, imm, pc, resw;
        logic        jmp, jalr, br, regw, memw;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        // expected
        logic        x_pcsrc;
        logic [31:0] x_target, x_alu, x_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        forwardae = v.fa;   forwardbe = v.fb;   alucontrole = v.op; alusrce = v.asrc;
        rd1e = v.rd1;       rd2e = v.rd2;       immexte = v.imm;    pce = v.pc;
        pcplus4e = v.pc + 32'd4;                resultw = v.resw;
        jumpe = v.jmp;      jalre = v.jalr;     branche = v.br;
        regwritee = v.regw; memwritee = v.memw; resultsrce = v.rsrc; rde = v.rd;
    endtask

    task automatic chk_m_zero(input string tag);
        chk({tag, ".regwritem"},  32'(regwritem),  32'd0);
        chk({tag, ".memwritem"},  32'(memwritem),  32'd0);
        chk({tag, ".resultsrcm"}, 32'(resultsrcm), 32'd0);
        chk({tag, ".aluresultm"}, aluresultm,      32'd0);
        chk({tag, ".writedatam"}, writedatam,      32'd0);
        chk({tag, ".rdm"},        32'(rdm),        32'd0);
        chk({tag, ".pcplus4m"},   pcplus4m,        32'd0);
    endtask

    // fa fb op asrc rd1 rd2 imm pc resw jmp jalr br regw memw rsrc rd | pcsrc target alu wd
    function automatic vec_t mk(logic [1:0] fa, logic [1:0] fb, logic [2:0] op, logic asrc,
                                logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                                logic [31:0] pc, logic [31:0] resw, logic jmp, logic jalr,
                                logic br, logic regw, logic memw, logic [1:0] rsrc,
                                logic [4:0] rd, logic xp, logic [31:0] xt,
                                logic [31:0] xa, logic [31:0] xw);
        vec_t v;
        v.fa = fa; v.fb = fb; v.op = op; v.asrc = asrc; v.rd1 = rd1; v.rd2 = rd2;
        v.imm = imm; v.pc = pc; v.resw = resw; v.jmp = jmp; v.jalr = jalr; v.br = br;
        v.regw = regw; v.memw = memw; v.rsrc = rsrc; v.rd = rd;
        v.x_pcsrc = xp; v.x_target = xt; v.x_alu = xa; v.x_wd = xw;
        return v;
    endfunction

    initial begin
        // Rows run back to back; rows using forward code 10 depend on the row before.
        vecs.push_back(mk(2'b00,2'b00,3'b000,0, 32'd5,32'd7,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd3,  0,32'h0,        32'd12,       32'd7));
        vecs.push_back(mk(2'b10,2'b00,3'b000,1, 32'd99,32'd7,32'd1, 32'h0,0, 0,0,0, 1,0,2'd0,5'd4,  0,32'h1,        32'd13,       32'd7));
        vecs.push_back(mk(2'b00,2'b01,3'b000,0, 32'd1,32'd3,32'd0, 32'h0,32'hA5, 0,0,0, 1,1,2'd1,5'd5, 0,32'h0,     32'hA6,       32'hA5));
        vecs.push_back(mk(2'b00,2'b00,3'b001,0, 32'd4,32'd4,32'hFFFFFFF0, 32'h100,0, 0,0,1, 0,0,2'd0,5'd0, 1,32'hF0, 32'h0,        32'd4));
        vecs.push_back(mk(2'b00,2'b00,3'b001,0, 32'd4,32'd5,32'hFFFFFFF0, 32'h100,0, 0,0,1, 0,0,2'd0,5'd0, 0,32'hF0, 32'hFFFFFFFF, 32'd5));
        vecs.push_back(mk(2'b00,2'b00,3'b001,0, 32'd4,32'd4,32'h8, 32'h100,0, 0,0,0, 0,0,2'd0,5'd0,   0,32'h108,    32'h0,        32'd4));
        vecs.push_back(mk(2'b00,2'b00,3'b000,1, 32'h203,32'd0,32'd4, 32'h100,0, 0,1,0, 1,0,2'd2,5'd1, 1,32'h206,  32'h207,      32'd0));
        vecs.push_back(mk(2'b00,2'b00,3'b000,1, 32'h203,32'd0,32'd4, 32'h100,0, 1,1,0, 1,0,2'd2,5'd1, 1,32'h206,  32'h207,      32'd0));
        vecs.push_back(mk(2'b00,2'b00,3'b101,0, 32'hFFFFFFFF,32'd1,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd6, 0,32'h0, 32'd1,        32'd1));
        vecs.push_back(mk(2'b00,2'b00,3'b101,0, 32'd1,32'hFFFFFFFF,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd6, 0,32'h0, 32'd0,        32'hFFFFFFFF));
        vecs.push_back(mk(2'b00,2'b00,3'b111,1, 32'h80000000,32'd0,32'h21, 32'h0,0, 0,0,0, 1,0,2'd0,5'd7, 0,32'h21, 32'h40000000, 32'd0));
        vecs.push_back(mk(2'b00,2'b00,3'b110,1, 32'd1,32'd0,32'h3F, 32'h0,0, 0,0,0, 1,0,2'd0,5'd8,    0,32'h3F,     32'h80000000, 32'd0));
        vecs.push_back(mk(2'b00,2'b00,3'b010,0, 32'hF0F0F0F0,32'h0FF00FF0,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd9,  0,32'h0, 32'h00F000F0, 32'h0FF00FF0));
        vecs.push_back(mk(2'b00,2'b00,3'b011,0, 32'hF0F0F0F0,32'h0F0F0000,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd10, 0,32'h0, 32'hFFFFF0F0, 32'h0F0F0000));
        vecs.push_back(mk(2'b00,2'b00,3'b100,0, 32'hFFFF0000,32'h0F0F0F0F,32'd0, 32'h0,0, 0,0,0, 1,0,2'd0,5'd11, 0,32'h0, 32'hF0F00F0F, 32'h0F0F0F0F));
        vecs.push_back(mk(2'b11,2'b11,3'b000,0, 32'd10,32'd20,32'd0, 32'h0,32'd99, 0,0,0, 1,0,2'd0,5'd12, 0,32'h0, 32'd30,        32'd20));
        vecs.push_back(mk(2'b00,2'b00,3'b000,0, 32'd3,32'd4,32'h20, 32'hFFFFFFF0,0, 1,0,0, 1,0,2'd2,5'd13, 1,32'h10, 32'd7,        32'd4));
        vecs.push_back(mk(2'b00,2'b10,3'b000,0, 32'd1,32'd55,32'd0, 32'h0,0, 0,0,0, 1,1,2'd0,5'd14, 0,32'h0,    32'd8,        32'd7));

        // Reset with live inputs: all M outputs cleared.
        drive(vecs[0]);
        memwritee = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_m_zero("reset");

        // Reset does not gate the combinational redirect.
        @(negedge clk);
        drive(vecs[6]);
        #1;
        chk("reset.pcsrce",    32'(pcsrce), 32'd1);
        chk("reset.pctargete", pctargete,   32'h206);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.pcsrce", i),    32'(pcsrce), 32'(vecs[i].x_pcsrc));
            chk($sformatf("v%0d.pctargete", i), pctargete,   vecs[i].x_target);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.aluresultm", i), aluresultm,       vecs[i].x_alu);
            chk($sformatf("v%0d.writedatam", i), writedatam,       vecs[i].x_wd);
            chk($sformatf("v%0d.rdm", i),        32'(rdm),         32'(vecs[i].rd));
            chk($sformatf("v%0d.regwritem", i),  32'(regwritem),   32'(vecs[i].regw));
            chk($sformatf("v%0d.memwritem", i),  32'(memwritem),   32'(vecs[i].memw));
            chk($sformatf("v%0d.resultsrcm", i), 32'(resultsrcm),  32'(vecs[i].rsrc));
            chk($sformatf("v%0d.pcplus4m", i),   pcplus4m,         vecs[i].pc + 32'd4);
            @(negedge clk);
        end

        // Store in flight: visible in M, then a one-cycle reset squashes it.
        drive(vecs[2]);
        @(posedge clk);
        #1 chk("store.memwritem", 32'(memwritem), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_m_zero("midreset");

        // Store presented while reset is high is dropped too.
        @(negedge clk);
        drive(vecs[2]);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_m_zero("dropped");

        // First instruction after reset passes through normally.
        @(negedge clk);
        rst = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        #1;
        chk("post.aluresultm", aluresultm,     32'd12);
        chk("post.rdm",        32'(rdm),       32'd3);
        chk("post.regwritem",  32'(regwritem), 32'd1);
        chk("post.memwritem",  32'(memwritem), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the five-stage RV32I pipeline. It sits directly downstream of the decode/execute pipeline register and consumes its E-suffixed outputs.
- Contains the forwarding muxes, ALU, branch/jump resolution, and the execute/memory pipeline register.
- Branch resolution results (pcsrce, pctargete) go combinationally to the fetch PC mux and the hazard unit. All M-suffixed outputs are registered.

Parameters:
DATA_WIDTH, 32, datapath width
ADDRESS_WIDTH, 32, PC/address width
WRITE_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
regwritee  in  1  register write enable, E stage
resultsrce  in  2  writeback result select
memwritee  in  1  memory write enable
jumpe  in  1  JAL
jalre  in  1  JALR
branche  in  1  BEQ-type branch
alucontrole  in  3  ALU op
alusrce  in  1  1: SrcB=immexte, 0: forwarded rd2
rd1e, rd2e  in  DATA_WIDTH  register file read data
immexte  in  DATA_WIDTH  extended immediate
pce, pcplus4e  in  ADDRESS_WIDTH  PC and PC+4
rde  in  WRITE_WIDTH  destination register
forwardae, forwardbe  in  2  from hazard unit: 00 rdXe, 01 resultw, 10 aluresultm, 11 treated as 00
resultw  in  DATA_WIDTH  writeback-stage result
pcsrce  out  1  redirect fetch (combinational)
pctargete  out  ADDRESS_WIDTH  redirect target (combinational)
regwritem, memwritem  out  1  registered controls
resultsrcm  out  2  registered result select
aluresultm  out  DATA_WIDTH  registered ALU result (also forwarding source)
writedatam  out  DATA_WIDTH  registered forwarded rd2
rdm  out  WRITE_WIDTH  registered destination
pcplus4m  out  ADDRESS_WIDTH  registered PC+4

Behaviour:
- SrcA is selected by forwardae. The forwarded B value (writedatae) is selected by forwardbe. SrcB = alusrce ? immexte : writedatae.
- ALU ops, all modulo 2^32:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed; result 1 or 0)
  - 110 sll by SrcB[4:0]
  - 111 srl by SrcB[4:0]
- zero = (ALU result == 0).
- pcsrce = jumpe | jalre | (branche & zero).
- pctargete:
  - jalre=1: (SrcA + immexte) with bit 0 forced to 0.
  - Otherwise: pce + immexte; the carry out is discarded.
- jalre takes priority over jumpe/branche for the target. Both are purely combinational, with zero added latency.
- E/M register: on each rising clk, capture regwritee, resultsrce, memwritee, ALU result, writedatae, rde and pcplus4e into the M outputs. Latency is 1 cycle.
- Reset: when rst=1 at a rising edge, all M outputs are cleared to 0 the next cycle, regardless of inputs. Reset mid-instruction drops that instruction and issues no memory write.
- While rst is asserted, pcsrce/pctargete still follow the inputs. The hazard unit and PC logic handle reset.
- There is no stall input. The E/M register updates every cycle; bubbles arrive as zeroed controls from the decode/execute register flush.
- Forwarding with forwardXe=10 uses the current aluresultm, i.e. the instruction one ahead. Back-to-back dependent ALU ops must produce correct results with no bubble.

Test Plan:
1. Reset, then rd1e=5, rd2e=7, alusrce=0, alucontrole=000, regwritee=1, rde=3 → next cycle aluresultm=12, rdm=3, regwritem=1; pcsrce=0.
2. Cycle 1: add writes aluresultm=12. Cycle 2: forwardae=10, rd1e=99, immexte=1, alusrce=1 → aluresultm=13. Repeat with forwardbe=01, resultw=0xA5 → writedatam=0xA5.
3. pce=0x100, immexte=0xFFFFFFF0 (-16), branche=1, sub with rd1e=rd2e=4 → pcsrce=1, pctargete=0xF0. With rd2e=5 → pcsrce=0.
4. jalre=1, rd1e=0x203, immexte=4 → pctargete=0x206, pcsrce=1. With jumpe=1 also set, the target is unchanged.
5. alucontrole=101, rd1e=0xFFFFFFFF, rd2e=1 → aluresultm=1. alucontrole=111, rd1e=0x80000000, SrcB=0x21 → aluresultm=0x40000000 (shift amount 1).
6. memwritee=1 in flight, rst asserted for one cycle → memwritem=0 and all M outputs 0. The next instruction after deassertion passes through normally.
